// File: rtl/mult_job_if.sv
// ---------------------------------------------------------------------------
// mult_job_if
// Bundles the command and datapath-control signals of the multiply job
// sequencer so the sequencer and its surroundings connect through one port.
//
//   master : command source / datapath side. Drives the job request
//            (start, abort, base_a, base_b, ram_base, count) and mul_valid.
//            Observes busy, done, register-file, multiplier, RAM controls
//            and st_out.
//   slave  : the sequencer itself (opposite directions).
// ---------------------------------------------------------------------------
interface mult_job_if #(
    parameter int ADDR_W = 3,
    parameter int RAM_AW = 3,
    parameter int CNT_W  = 4
);
    // job request from the command source
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [RAM_AW-1:0] ram_base;
    logic [CNT_W-1:0]  count;
    // multiplier handshake back into the sequencer
    logic              mul_valid;
    // status
    logic              busy;
    logic              done;
    // datapath controls
    logic              rf_rd;
    logic [ADDR_W-1:0] rf_adr_a;
    logic [ADDR_W-1:0] rf_adr_b;
    logic              mul_en;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_adr;
    logic [2:0]        st_out;

    modport master (
        output start, abort, base_a, base_b, ram_base, count, mul_valid,
        input  busy, done, rf_rd, rf_adr_a, rf_adr_b, mul_en, ram_we,
               ram_adr, st_out
    );

    modport slave (
        input  start, abort, base_a, base_b, ram_base, count, mul_valid,
        output busy, done, rf_rd, rf_adr_a, rf_adr_b, mul_en, ram_we,
               ram_adr, st_out
    );
endinterface

// File: rtl/mult_job_sequencer.sv
// ---------------------------------------------------------------------------
// mult_job_sequencer
// Runs a block of count operand pairs through the shared register-file ->
// multiplier -> RAM datapath. Pair i is read from (base_a+i, base_b+i), the
// multiplier is strobed, the sequencer waits for the product and then writes
// it to RAM at ram_base+i. Address arithmetic wraps modulo the address width.
//
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : mult_job_if.slave
//              in : start, abort, base_a, base_b, ram_base, count, mul_valid
//              out: busy, done, rf_rd, rf_adr_a, rf_adr_b, mul_en, ram_we,
//                   ram_adr, st_out
//
// Every output comes straight from a flop: the FSM computes the values for
// the state it is entering, so there is no input-to-output combinational path
// and st_out is simply the state register.
// ---------------------------------------------------------------------------
module mult_job_sequencer #(
    parameter int ADDR_W = 3,
    parameter int RAM_AW = 3,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       reset,
    mult_job_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_MULT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_r;

    // job registers, latched once on acceptance
    logic [ADDR_W-1:0] base_a_r;
    logic [ADDR_W-1:0] base_b_r;
    logic [RAM_AW-1:0] ram_base_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  idx_r;

    // registered outputs
    logic              busy_r;
    logic              done_r;
    logic              rf_rd_r;
    logic [ADDR_W-1:0] rf_adr_a_r;
    logic [ADDR_W-1:0] rf_adr_b_r;
    logic              mul_en_r;
    logic              ram_we_r;
    logic [RAM_AW-1:0] ram_adr_r;

    // derived values used by the FSM
    logic [CNT_W-1:0]  idx_next_s;
    logic              last_pair_s;
    logic [ADDR_W-1:0] adr_a_next_s;
    logic [ADDR_W-1:0] adr_b_next_s;
    logic [RAM_AW-1:0] ram_adr_cur_s;

    // Next-index arithmetic; casts truncate so the sums wrap naturally.
    always_comb begin
        idx_next_s    = idx_r + CNT_W'(1);
        last_pair_s   = (idx_next_s == count_r);
        adr_a_next_s  = base_a_r + ADDR_W'(idx_next_s);
        adr_b_next_s  = base_b_r + ADDR_W'(idx_next_s);
        ram_adr_cur_s = ram_base_r + RAM_AW'(idx_r);
    end

    // Job FSM: state, job registers and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            base_a_r   <= {ADDR_W{1'b0}};
            base_b_r   <= {ADDR_W{1'b0}};
            ram_base_r <= {RAM_AW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            idx_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rf_rd_r    <= 1'b0;
            rf_adr_a_r <= {ADDR_W{1'b0}};
            rf_adr_b_r <= {ADDR_W{1'b0}};
            mul_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_adr_r  <= {RAM_AW{1'b0}};
        end else begin
            // strobes are single-cycle unless the branch below re-asserts them
            done_r   <= 1'b0;
            rf_rd_r  <= 1'b0;
            mul_en_r <= 1'b0;
            ram_we_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        if (bus.count != {CNT_W{1'b0}}) begin
                            base_a_r   <= bus.base_a;
                            base_b_r   <= bus.base_b;
                            ram_base_r <= bus.ram_base;
                            count_r    <= bus.count;
                            // first pair is at idx 0, so the bases are the addresses
                            rf_rd_r    <= 1'b1;
                            rf_adr_a_r <= bus.base_a;
                            rf_adr_b_r <= bus.base_b;
                            state_r    <= ST_FETCH;
                        end else begin
                            // empty job: report completion without touching the datapath
                            done_r  <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end

                ST_FETCH: begin
                    if (bus.abort) begin
                        idx_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        mul_en_r <= 1'b1;
                        state_r  <= ST_MULT;
                    end
                end

                ST_MULT: begin
                    if (bus.abort) begin
                        idx_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // abort has priority over a product arriving in the same cycle
                    if (bus.abort) begin
                        idx_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (bus.mul_valid) begin
                        ram_we_r  <= 1'b1;
                        ram_adr_r <= ram_adr_cur_s;
                        state_r   <= ST_WRITE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                ST_WRITE: begin
                    // the write strobe is already on the bus this cycle, so an
                    // abort here still lets it complete
                    if (bus.abort) begin
                        idx_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (last_pair_s) begin
                        idx_r   <= idx_next_s;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r      <= idx_next_s;
                        rf_rd_r    <= 1'b1;
                        rf_adr_a_r <= adr_a_next_s;
                        rf_adr_b_r <= adr_b_next_s;
                        state_r    <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    // unreachable codes recover to IDLE
                    idx_r   <= {CNT_W{1'b0}};
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.rf_rd    = rf_rd_r;
    assign bus.rf_adr_a = rf_adr_a_r;
    assign bus.rf_adr_b = rf_adr_b_r;
    assign bus.mul_en   = mul_en_r;
    assign bus.ram_we   = ram_we_r;
    assign bus.ram_adr  = ram_adr_r;
    assign bus.st_out   = state_r;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_job_sequencer
// Scoreboard bench: the stimulus process pushes the expected register-file
// pairs, multiplier strobes, RAM addresses and done cycles for every job it
// issues; a negedge monitor pops and compares whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_mult_job_sequencer;
    localparam int AW = 3;
    localparam int RW = 3;
    localparam int CW = 4;
    localparam int AMOD = 1 << AW;
    localparam int RMOD = 1 << RW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mult_job_if #(.ADDR_W(AW), .RAM_AW(RW), .CNT_W(CW)) bus ();

    mult_job_sequencer #(.ADDR_W(AW), .RAM_AW(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    int rf_q[$];
    int mul_q[$];
    int wr_q[$];
    int done_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: compares every DUT strobe against the scoreboard queues
    always @(negedge clk) begin
        int e;
        if (!reset) begin
            chk("busy vs state", int'(bus.busy), int'(bus.st_out != 3'd0));
            if (bus.rf_rd) begin
                if (rf_q.size() == 0) chk("rf_rd unexpected", 1, 0);
                else begin
                    e = rf_q.pop_front();
                    chk("rf pair", int'(bus.rf_adr_a) * AMOD + int'(bus.rf_adr_b), e);
                end
            end
            if (bus.mul_en) begin
                if (mul_q.size() == 0) chk("mul_en unexpected", 1, 0);
                else begin
                    e = mul_q.pop_front();
                    chk("mul pair", int'(bus.rf_adr_a) * AMOD + int'(bus.rf_adr_b), e);
                end
            end
            if (bus.ram_we) begin
                if (wr_q.size() == 0) chk("ram_we unexpected", 1, 0);
                else begin
                    e = wr_q.pop_front();
                    chk("ram_adr", int'(bus.ram_adr), e);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("done unexpected", 1, 0);
                else begin
                    e = done_q.pop_front();
                    if (e >= 0) chk("done cycle", cyc, e);
                end
            end
        end
    end

    // reference model: n_rd pairs read/multiplied, n_wr products written
    task automatic push_job(input int ba, input int bb, input int rb,
                            input int n_rd, input int n_wr,
                            input bit has_done, input int lat);
        for (int i = 0; i < n_rd; i++) begin
            rf_q.push_back(((ba + i) % AMOD) * AMOD + ((bb + i) % AMOD));
            mul_q.push_back(((ba + i) % AMOD) * AMOD + ((bb + i) % AMOD));
        end
        for (int i = 0; i < n_wr; i++) wr_q.push_back((rb + i) % RMOD);
        if (has_done) done_q.push_back(lat);
    endtask

    // mode 0: no model push, 1: full job with exact latency, 2: full job, latency unchecked
    task automatic start_job(input int ba, input int bb, input int rb,
                             input int cnt, input int mode);
        bus.base_a   = AW'(ba);
        bus.base_b   = AW'(bb);
        bus.ram_base = RW'(rb);
        bus.count    = CW'(cnt);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (mode == 1) push_job(ba, bb, rb, cnt, cnt, 1'b1, cyc + 4 * cnt);
        else if (mode == 2) push_job(ba, bb, rb, cnt, cnt, 1'b1, -1);
    endtask

    task automatic wait_st(input int code);
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (int'(bus.st_out) == code) break;
        end
        chk("wait st_out", int'(bus.st_out), code);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200; k++) begin
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
        chk("job end busy", int'(bus.busy), 0);
    endtask

    initial begin
        int exp_st;
        bus.start = 1'b0; bus.abort = 1'b0; bus.mul_valid = 1'b0;
        bus.base_a = '0; bus.base_b = '0; bus.ram_base = '0; bus.count = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk("rst st_out", int'(bus.st_out), 0);
        chk("rst busy", int'(bus.busy), 0);
        chk("rst done", int'(bus.done), 0);
        chk("rst rf_rd", int'(bus.rf_rd), 0);
        chk("rst rf_adr_a", int'(bus.rf_adr_a), 0);
        chk("rst rf_adr_b", int'(bus.rf_adr_b), 0);
        chk("rst mul_en", int'(bus.mul_en), 0);
        chk("rst ram_we", int'(bus.ram_we), 0);
        chk("rst ram_adr", int'(bus.ram_adr), 0);

        // basic 3-pair job, product always ready: state trace and latency
        bus.mul_valid = 1'b1;
        start_job(1, 4, 2, 3, 1);
        for (int c = 1; c <= 14; c++) begin
            exp_st = (c <= 12) ? ((c - 1) % 4 + 1) : ((c == 13) ? 5 : 0);
            chk("t1 st_out", int'(bus.st_out), exp_st);
            @(posedge clk); #1;
        end

        // empty job
        start_job(0, 0, 0, 0, 1);
        chk("t2 st_out", int'(bus.st_out), 5);
        chk("t2 busy", int'(bus.busy), 1);
        @(posedge clk); #1;
        chk("t2 busy after", int'(bus.busy), 0);
        chk("t2 st_out after", int'(bus.st_out), 0);

        // address wrap
        start_job(6, 0, 7, 3, 1);
        wait_idle();

        // delayed product
        bus.mul_valid = 1'b0;
        start_job(3, 5, 1, 2, 2);
        wait_st(3);
        for (int k = 0; k < 3; k++) begin
            chk("t4 wait st_out", int'(bus.st_out), 3);
            chk("t4 wait ram_we", int'(bus.ram_we), 0);
            if (k < 2) begin @(posedge clk); #1; end
        end
        bus.mul_valid = 1'b1;
        @(posedge clk); #1;
        chk("t4 write st_out", int'(bus.st_out), 4);
        wait_idle();
        // mul_valid while idle does nothing
        repeat (3) begin
            @(posedge clk); #1;
            chk("t4 idle st_out", int'(bus.st_out), 0);
        end

        // start pulsed mid-job is ignored
        start_job(2, 1, 3, 3, 1);
        @(posedge clk); #1;
        bus.base_a = 3'd5; bus.base_b = 3'd6; bus.ram_base = 3'd0; bus.count = 4'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();

        // abort in WAIT of pair 1 together with mul_valid
        bus.mul_valid = 1'b0;
        start_job(2, 3, 5, 4, 0);
        push_job(2, 3, 5, 2, 1, 1'b0, -1);
        wait_st(3);
        bus.mul_valid = 1'b1;
        @(posedge clk); #1;
        bus.mul_valid = 1'b0;
        wait_st(3);
        bus.abort = 1'b1; bus.mul_valid = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0; bus.mul_valid = 1'b0;
        chk("abort st_out", int'(bus.st_out), 0);
        chk("abort ram_we", int'(bus.ram_we), 0);
        chk("abort done", int'(bus.done), 0);
        bus.mul_valid = 1'b1;
        start_job(7, 7, 6, 1, 1);
        wait_idle();

        // randomized jobs with random product delays and ignored mid-job starts
        for (int j = 0; j < 25; j++) begin
            start_job(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 2);
            for (int k = 0; k < 200; k++) begin
                if (!bus.busy) break;
                bus.mul_valid = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 4) == 0) begin
                    bus.base_a = AW'($urandom); bus.base_b = AW'($urandom);
                    bus.ram_base = RW'($urandom); bus.count = CW'($urandom);
                    bus.start = 1'b1;
                end
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            chk("rand job end", int'(bus.busy), 0);
        end
        bus.mul_valid = 1'b1;

        // asynchronous reset in the middle of a WRITE cycle
        start_job(0, 1, 2, 3, 0);
        push_job(0, 1, 2, 1, 0, 1'b0, -1);
        wait_st(4);
        #1 reset = 1'b1;
        #1;
        chk("arst ram_we", int'(bus.ram_we), 0);
        chk("arst busy", int'(bus.busy), 0);
        chk("arst st_out", int'(bus.st_out), 0);
        rf_q.delete(); mul_q.delete(); wr_q.delete(); done_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post rst st_out", int'(bus.st_out), 0);
        end
        bus.mul_valid = 1'b0;

        chk("rf_q left", rf_q.size(), 0);
        chk("mul_q left", mul_q.size(), 0);
        chk("wr_q left", wr_q.size(), 0);
        chk("done_q left", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Sequences the shared register-file → multiplier → RAM datapath over a block of N operand pairs per job, replacing one-shot single-product control.
Accepts a job (two register-file base addresses, a RAM base address and a count) and fetches pair i from (base_a+i, base_b+i).
Waits for the multiplier's product, then writes it to RAM at ram_base+i.
Sits between the top-level command source and the register file, multiplier and RAM.

Parameters:
ADDR_W, 3, register-file address width
RAM_AW, 3, RAM address width
CNT_W, 4, job count width (max job length 2^CNT_W-1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  job request; sampled only in IDLE
abort  in  1  synchronous job cancel; ignored in IDLE and DONE
base_a  in  ADDR_W  register-file base address, operand A
base_b  in  ADDR_W  register-file base address, operand B
ram_base  in  RAM_AW  RAM base address for products
count  in  CNT_W  number of products in the job
mul_valid  in  1  multiplier product valid; sampled only in WAIT
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on job completion
rf_rd  out  1  register-file read enable
rf_adr_a  out  ADDR_W  operand A address
rf_adr_b  out  ADDR_W  operand B address
mul_en  out  1  operands-valid strobe to multiplier
ram_we  out  1  RAM write enable
ram_adr  out  RAM_AW  RAM write address
st_out  out  3  current state code, for debug LEDs

Behaviour:
- Reset:
  - Asynchronous, active-high, effective immediately with no clock edge required.
  - State goes to IDLE; idx and all latched job registers clear to 0.
  - All outputs are 0, including addresses and st_out.
- State codes: IDLE=0, FETCH=1, MULT=2, WAIT=3, WRITE=4, DONE=5. Codes 6 and 7 are illegal and go to IDLE on the next edge.
- Outputs are Moore-decoded from the state register and the registered idx and job registers. No input-to-output combinational path exists.
- IDLE:
  - start=1 with count≠0: latch base_a, base_b, ram_base and count; clear idx; go to FETCH.
  - start=1 with count=0: go to DONE; no register-file, multiplier or RAM activity.
- FETCH: rf_rd=1; rf_adr_a=base_a+idx and rf_adr_b=base_b+idx, both mod 2^ADDR_W. Next state is MULT.
- MULT: mul_en=1 for exactly one cycle; rf addresses held. Next state is WAIT.
- WAIT:
  - Hold until mul_valid=1, then go to WRITE.
  - No timeout; the minimum stay is one cycle.
  - mul_valid in any other state is ignored.
- WRITE:
  - ram_we=1 for exactly one cycle; ram_adr=ram_base+idx mod 2^RAM_AW.
  - idx increments.
  - If idx+1==count, go to DONE; otherwise go to FETCH.
- DONE: done=1 and busy=1 for one cycle. Next state is IDLE.
- rf_adr_*: hold their last value outside FETCH, MULT and WAIT.
- ram_adr: holds its last value outside WRITE.
- Latency:
  - Each pair takes 4 cycles plus any extra WAIT cycles.
  - With mul_valid held at 1, done asserts in cycle 4N+1 after the accepting edge.
  - A count=0 job asserts done in cycle 1.
- Handshake:
  - start is ignored while busy=1; no queuing.
  - A new start is accepted in the IDLE cycle that follows DONE.
- abort:
  - In FETCH, MULT, WAIT or WRITE, abort forces IDLE on the next edge.
  - A write in that same WRITE cycle still completes.
  - No done pulse is issued, and idx clears.
  - If abort and mul_valid arrive together in WAIT, abort wins.
- Job inputs are not sampled after acceptance; changing them mid-job has no effect.

Test Plan:
1. Reset, then start with count=3, base_a=1, base_b=4, ram_base=2, mul_valid tied 1 → rf pairs (1,4),(2,5),(3,6); ram_we at ram_adr 2,3,4; done pulses once, 13 cycles after the accepting edge; st_out cycles 1,2,3,4 per pair, then 5, then 0.
2. start with count=0 → done in the next cycle; rf_rd, mul_en and ram_we never assert; busy high for exactly that one cycle.
3. Wrap: base_a=6, base_b=0, ram_base=7, count=3 → rf_adr_a 6,7,0; rf_adr_b 0,1,2; ram_adr 7,0,1.
4. mul_valid delayed 3 cycles after MULT → st_out stays 3 for 3 cycles and ram_we stays 0 until valid. A mul_valid pulse while IDLE causes no activity.
5. start pulsed mid-job → ignored, job result unchanged. abort asserted in WAIT with mul_valid=1 → IDLE next cycle, no ram_we, no done; a following start with count=1 completes normally.
6. reset asserted asynchronously mid-WRITE, between clock edges → ram_we, busy and st_out drop to 0 immediately; after reset release, state stays IDLE until start.
